axis_byte_upsizer: RTL and testbench
====================================

Name: axis_byte_upsizer

Overview:
- Parametrised AXI-Stream width upsizer with byte-granular packing. Supports non-integer width ratios, e.g. 4→17 bytes for the 32→136 hash-data path and 4→32 bytes for the 32→256 tap path.
- Handles partial beats via TKEEP and packet boundaries via TLAST, and carries TDEST through.
- Replaces vendor width-converter IP between the input stream switch and the SystemC-generated DUT ports.

Parameters:
- IN_BYTES, 4, input beat width in bytes; must be ≥1.
- OUT_BYTES, 17, output beat width in bytes; must be > IN_BYTES.
- DEST_W, 1, TDEST width.
- Derived: BUF_BYTES = OUT_BYTES + IN_BYTES, the internal byte buffer depth.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, reset; synchronous, active-low.
- s_axis_tdata, in, 8*IN_BYTES, input data; byte 0 is at the LSBs.
- s_axis_tkeep, in, IN_BYTES, input byte enables.
- s_axis_tlast, in, 1, end of packet.
- s_axis_tdest, in, DEST_W, destination.
- s_axis_tvalid, in, 1, input valid.
- s_axis_tready, out, 1, input ready.
- m_axis_tdata, out, 8*OUT_BYTES, packed output data.
- m_axis_tkeep, out, OUT_BYTES, output byte enables; always low-contiguous.
- m_axis_tlast, out, 1, end of packet.
- m_axis_tdest, out, DEST_W, destination latched from the first input beat of the packet.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tready, in, 1, output ready.
- err_keep, out, 1, sticky flag: a non-contiguous input TKEEP was seen.
- pkt_count, out, 16, number of output TLAST beats sent; wraps at 2^16.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - Clears byte count, last_pending, err_keep, pkt_count and tdest_q.
  - All outputs are 0 during the cycle following reset assertion; s_axis_tready is also 0 while aresetn=0.
  - Reset mid-packet discards all buffered bytes and emits no partial beat.
- Input beat valid-byte count n:
  - n = number of contiguous 1s in TKEEP starting at bit 0.
  - Bytes above the first 0 are dropped.
  - If TKEEP is non-contiguous, err_keep is set (sticky until reset).
  - A beat with TKEEP=0 and TLAST=0 is accepted and ignored.
- State: byte buffer buf[BUF_BYTES], count (0..BUF_BYTES), last_pending, first_beat.
- s_axis_tready = aresetn && !last_pending && (count ≤ OUT_BYTES). It depends only on registered state; there is no combinational path from m_axis_tready.
- m_axis_tvalid = (count ≥ OUT_BYTES) || (last_pending && count > 0) || (last_pending && count == 0 && zero_len_last).
- Output beat contents:
  - m_axis_tdata carries buf[0..k-1] with k = min(count, OUT_BYTES). Unused bytes are driven to 0.
  - m_axis_tkeep = (1<<k)-1.
  - m_axis_tlast = last_pending && (count ≤ OUT_BYTES).
- Zero-length packet (TLAST with TKEEP=0 and an empty buffer): emits one beat with tkeep=0 and tlast=1.
- Output fire (tvalid && tready):
  - Shift the buffer down by k bytes and set count -= k.
  - If tlast was set, clear last_pending, set first_beat=1 and increment pkt_count.
- Input fire:
  - Append n bytes at position count (after the shift, if an output fired in the same cycle).
  - Next count = count − k_out + n.
  - If TLAST, set last_pending.
  - On first_beat, latch tdest_q and clear first_beat.
- Simultaneous input and output fire is legal and sustains full throughput. Steady state gives 1 input beat per cycle and an output beat every ceil(OUT_BYTES/IN_BYTES) or floor(OUT_BYTES/IN_BYTES) cycles.
- Latency: the first output is valid the cycle after the input beat that brings count ≥ OUT_BYTES or carries TLAST.
- Full: when count > OUT_BYTES, s_axis_tready=0 until an output fires. There is no overflow, since max count = OUT_BYTES + IN_BYTES = BUF_BYTES.
- TLAST ending exactly on an OUT_BYTES boundary: the final full beat carries tlast=1 and no extra empty beat is emitted.
- While last_pending, input is stalled until the final beat drains. Packets are never merged into one output beat.

Decomposition:
- Package axis_pkg:
  - function keep_len(keep) returning the contiguous-ones count;
  - function keep_mask(k);
  - function is_contig(keep);
  - typedef byte_t.
- One sub-module, axis_byte_shiftbuf: holds the byte buffer and count, and implements combined shift-out-k / append-n at offset in one cycle. The top level holds the handshake, last/tdest and error logic.

Test Plan (IN_BYTES=4, OUT_BYTES=17):
- 17 beats of bytes 0x00..0x43, tkeep=4'hF, no tlast, m_tready=1 → 4 output beats, each tkeep=17'h1FFFF and tlast=0. Beat 0 tdata bytes are 0x00..0x10 with 0x00 at the LSB. No stall on s_tready.
- 5-beat packet (20 bytes), last beat tlast=1, tdest=1 → beat A: 17 bytes, tlast=0, tdest=1; beat B: 3 bytes, tkeep=17'h00007, tlast=1, tdest=1; pkt_count=1.
- 4 beats tkeep=4'hF, then 1 beat tkeep=4'h1 with tlast=1 (17 bytes) → exactly one beat with tkeep=17'h1FFFF and tlast=1; no trailing empty beat.
- m_tready held 0, 10 full beats offered → s_tready drops after the 5th beat (count=20). Releasing m_tready gives byte-exact output with no loss or duplication.
- One beat with tkeep=4'b0101, tlast=1, data 0xDDCCBBAA → err_keep=1; output is 1 byte 0xAA, tkeep=17'h00001, tlast=1.
- aresetn=0 for 1 cycle after 3 beats of a packet → all outputs 0 next cycle. A new 17-byte packet then yields one correct beat carrying none of the old bytes.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared byte/keep helpers for the AXI-Stream byte upsizer.
// Keep vectors are zero-extended to MAX_BYTES before being passed in.
package axis_pkg;

  localparam int MAX_BYTES = 64;

  typedef logic [7:0] byte_t;

  function automatic int keep_len(input logic [MAX_BYTES-1:0] keep);
    int  n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (run && keep[i]) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [MAX_BYTES-1:0] keep_mask(input int k);
    logic [MAX_BYTES-1:0] m;
    for (int i = 0; i < MAX_BYTES; i++) m[i] = (i < k);
    return m;
  endfunction

  function automatic logic is_contig(input logic [MAX_BYTES-1:0] keep);
    return keep == keep_mask(keep_len(keep));
  endfunction

endpackage

// File: rtl/axis_byte_shiftbuf.sv
// Byte buffer with a combined shift-out-k / append-n update in a single cycle.
// The append offset is the count left after the shift.
module axis_byte_shiftbuf
  import axis_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int OUT_BYTES = 17,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       shift_k,
  input  logic [CNT_W-1:0]       push_n,
  input  logic [8*IN_BYTES-1:0]  push_data,
  output logic [CNT_W-1:0]       count_o,
  output logic [8*OUT_BYTES-1:0] head_o
);

  localparam int BUF_BYTES = OUT_BYTES + IN_BYTES;

  byte_t            mem_q [BUF_BYTES];
  byte_t            mem_d [BUF_BYTES];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] base;

  always_comb begin
    base    = count_q - shift_k;
    count_d = base + push_n;
    for (int i = 0; i < BUF_BYTES; i++) begin
      mem_d[i] = 8'h00;
      for (int s = 0; s < BUF_BYTES - i; s++) begin
        if (int'(shift_k) == s) mem_d[i] = mem_q[i + s];
      end
      for (int j = 0; j < IN_BYTES; j++) begin
        if (j < int'(push_n) && int'(base) + j == i) mem_d[i] = push_data[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < BUF_BYTES; i++) mem_q[i] <= 8'h00;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < BUF_BYTES; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < OUT_BYTES; i++) head_o[8*i +: 8] = mem_q[i];
  end

  assign count_o = count_q;

endmodule

// File: rtl/axis_byte_upsizer.sv
// AXI-Stream byte-granular width upsizer: handshake, TLAST/TDEST tracking and keep error.
// Byte storage and packing live in axis_byte_shiftbuf.
module axis_byte_upsizer
  import axis_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int OUT_BYTES = 17,
  parameter int DEST_W    = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [8*IN_BYTES-1:0]  s_axis_tdata,
  input  logic [IN_BYTES-1:0]    s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [DEST_W-1:0]      s_axis_tdest,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [8*OUT_BYTES-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [DEST_W-1:0]      m_axis_tdest,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   err_keep,
  output logic [15:0]            pkt_count
);

  localparam int BUF_BYTES = OUT_BYTES + IN_BYTES;
  localparam int CNT_W     = $clog2(BUF_BYTES + 1);
  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_BYTES);

  logic [CNT_W-1:0]       buf_count;
  logic [CNT_W-1:0]       k_out;
  logic [CNT_W-1:0]       n_in;
  logic [CNT_W-1:0]       shift_k;
  logic [CNT_W-1:0]       push_n;
  logic [CNT_W-1:0]       next_count;
  logic [8*OUT_BYTES-1:0] head;
  logic [MAX_BYTES-1:0]   keep_ext;
  logic                   keep_ok;
  logic                   in_fire;
  logic                   out_fire;

  logic                   last_pending_q;
  logic                   zero_len_q;
  logic                   first_beat_q;
  logic                   err_keep_q;
  logic                   rst_done_q;
  logic [DEST_W-1:0]      tdest_q;
  logic [15:0]            pkt_count_q;

  axis_byte_shiftbuf #(
    .IN_BYTES  (IN_BYTES),
    .OUT_BYTES (OUT_BYTES),
    .CNT_W     (CNT_W)
  ) u_shiftbuf (
    .clk       (aclk),
    .rst_n     (aresetn),
    .shift_k   (shift_k),
    .push_n    (push_n),
    .push_data (s_axis_tdata),
    .count_o   (buf_count),
    .head_o    (head)
  );

  // rst_done_q holds s_axis_tready low for the cycle right after a reset edge.
  always_comb begin
    keep_ext      = MAX_BYTES'(s_axis_tkeep);
    n_in          = CNT_W'(keep_len(keep_ext));
    keep_ok       = is_contig(keep_ext);
    k_out         = (buf_count > OUT_CNT) ? OUT_CNT : buf_count;
    m_axis_tvalid = (buf_count >= OUT_CNT) ||
                    (last_pending_q && (buf_count != '0 || zero_len_q));
    m_axis_tlast  = last_pending_q && (buf_count <= OUT_CNT);
    s_axis_tready = aresetn && rst_done_q && !last_pending_q && (buf_count <= OUT_CNT);
    out_fire      = m_axis_tvalid && m_axis_tready;
    in_fire       = s_axis_tvalid && s_axis_tready;
    shift_k       = out_fire ? k_out : '0;
    push_n        = in_fire ? n_in : '0;
    next_count    = buf_count - shift_k + push_n;
    m_axis_tkeep  = OUT_BYTES'(keep_mask(int'(k_out)));
    for (int i = 0; i < OUT_BYTES; i++) begin
      m_axis_tdata[8*i +: 8] = m_axis_tkeep[i] ? head[8*i +: 8] : 8'h00;
    end
  end

  // A final beat is never accepted while a tlast beat is still pending, so the
  // input and output tlast updates below cannot collide.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_pending_q <= 1'b0;
      zero_len_q     <= 1'b0;
      first_beat_q   <= 1'b1;
      err_keep_q     <= 1'b0;
      rst_done_q     <= 1'b0;
      tdest_q        <= '0;
      pkt_count_q    <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (in_fire && !keep_ok) err_keep_q <= 1'b1;
      if (out_fire && m_axis_tlast) begin
        last_pending_q <= 1'b0;
        zero_len_q     <= 1'b0;
        first_beat_q   <= 1'b1;
        pkt_count_q    <= pkt_count_q + 16'd1;
      end
      if (in_fire) begin
        if (s_axis_tlast) begin
          last_pending_q <= 1'b1;
          zero_len_q     <= (next_count == '0);
        end
        if (first_beat_q) begin
          tdest_q      <= s_axis_tdest;
          first_beat_q <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tdest = tdest_q;
  assign err_keep     = err_keep_q;
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_axis_byte_upsizer.sv
// Scoreboard bench for axis_byte_upsizer with IN_BYTES=4, OUT_BYTES=17.
module tb_axis_byte_upsizer;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [31:0]  s_tdata = '0;
  logic [3:0]   s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic [0:0]   s_tdest = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [135:0] m_tdata;
  logic [16:0]  m_tkeep;
  logic         m_tlast;
  logic [0:0]   m_tdest;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         err_keep;
  logic [15:0]  pkt_count;

  typedef struct {
    logic [135:0] data;
    logic [16:0]  keep;
    logic         last;
    logic [0:0]   dest;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   accepted = 0;
  int   stalls = 0;
  logic t4_done = 1'b0;

  axis_byte_upsizer #(
    .IN_BYTES  (4),
    .OUT_BYTES (17),
    .DEST_W    (1)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdest  (s_tdest),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tdest  (m_tdest),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .err_keep      (err_keep),
    .pkt_count     (pkt_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int first, input int n, input logic last, input logic [0:0] dest);
    exp_t e;
    e.data = '0;
    e.keep = '0;
    for (int i = 0; i < n; i++) begin
      e.data[8*i +: 8] = 8'(first + i);
      e.keep[i] = 1'b1;
    end
    e.last = last;
    e.dest = dest;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic [31:0] data, input logic [3:0] keep, input logic last,
                      input logic [0:0] dest);
    int guard = 0;
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tdest  = dest;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && guard < 300) begin
      stalls++;
      guard++;
      @(negedge aclk);
    end
    if (!s_tready) check("send_timeout", 136'(s_tready), 136'(1));
    else accepted++;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_seq(input int first, input logic [3:0] keep, input logic last,
                          input logic [0:0] dest);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(first + i);
    send(d, keep, last, dest);
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge aclk);
      guard++;
    end
    check(name, 136'(exp_q.size()), 136'(0));
    repeat (5) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_s_tready", 136'(s_tready), 136'(0));
    check("rst_m_tvalid", 136'(m_tvalid), 136'(0));
    check("rst_m_tdata", m_tdata, 136'(0));
    check("rst_m_tkeep", 136'(m_tkeep), 136'(0));
    check("rst_m_tlast", 136'(m_tlast), 136'(0));
    check("rst_m_tdest", 136'(m_tdest), 136'(0));
    check("rst_err_keep", 136'(err_keep), 136'(0));
    check("rst_pkt_count", 136'(pkt_count), 136'(0));
    @(posedge aclk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 136'(m_tvalid), 136'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_tdata, e.data);
          check("beat_keep", 136'(m_tkeep), 136'(e.keep));
          check("beat_last", 136'(m_tlast), 136'(e.last));
          check("beat_dest", 136'(m_tdest), 136'(e.dest));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin : stimulus
    m_tready = 1'b1;
    aresetn  = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("init_s_tready", 136'(s_tready), 136'(0));
    check("init_m_tvalid", 136'(m_tvalid), 136'(0));
    check("init_m_tkeep", 136'(m_tkeep), 136'(0));
    check("init_err_keep", 136'(err_keep), 136'(0));
    check("init_pkt_count", 136'(pkt_count), 136'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // 68 bytes, no tlast: four full output beats
    stalls = 0;
    accepted = 0;
    for (int b = 0; b < 4; b++) push_exp(17 * b, 17, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) send_seq(4 * i, 4'hF, 1'b0, 1'b0);
    wait_drain("t1_drain");
    check("t1_accepted", 136'(accepted), 136'(17));
    check("t1_stall_bound", 136'(stalls <= 5), 136'(1));
    check("t1_pkt_count", 136'(pkt_count), 136'(0));
    do_reset();

    // 20-byte packet with tdest=1: 17 + 3 bytes
    push_exp(8'h80, 17, 1'b0, 1'b1);
    push_exp(8'h91, 3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_seq(8'h80 + 4 * i, 4'hF, i == 4, 1'b1);
    wait_drain("t2_drain");
    check("t2_pkt_count", 136'(pkt_count), 136'(1));

    // exactly 17 bytes ending on a beat boundary
    push_exp(8'h20, 17, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_seq(8'h20 + 4 * i, 4'hF, 1'b0, 1'b0);
    send_seq(8'h30, 4'h1, 1'b1, 1'b0);
    wait_drain("t3_drain");
    check("t3_no_trailing", 136'(m_tvalid), 136'(0));
    check("t3_pkt_count", 136'(pkt_count), 136'(2));

    // backpressure: 10 full beats with output held off
    m_tready = 1'b0;
    accepted = 0;
    push_exp(8'h40, 17, 1'b0, 1'b0);
    push_exp(8'h51, 17, 1'b0, 1'b0);
    push_exp(8'h62, 6, 1'b1, 1'b0);
    fork
      begin
        for (int i = 0; i < 10; i++) send_seq(8'h40 + 4 * i, 4'hF, i == 9, 1'b0);
        t4_done = 1'b1;
      end
    join_none
    repeat (15) @(negedge aclk);
    check("t4_accepted_stalled", 136'(accepted), 136'(5));
    check("t4_s_tready_low", 136'(s_tready), 136'(0));
    check("t4_m_tvalid_high", 136'(m_tvalid), 136'(1));
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    for (int g = 0; g < 300 && !t4_done; g++) @(posedge aclk);
    #1;
    check("t4_sender_done", 136'(t4_done), 136'(1));
    wait_drain("t4_drain");
    check("t4_accepted", 136'(accepted), 136'(10));
    check("t4_pkt_count", 136'(pkt_count), 136'(3));

    // non-contiguous keep: only byte 0 survives
    check("t5_err_before", 136'(err_keep), 136'(0));
    push_exp(8'hAA, 1, 1'b1, 1'b0);
    send(32'hDDCCBBAA, 4'b0101, 1'b1, 1'b0);
    wait_drain("t5_drain");
    check("t5_err_after", 136'(err_keep), 136'(1));
    check("t5_pkt_count", 136'(pkt_count), 136'(4));

    // reset mid-packet, then a clean 17-byte packet
    for (int i = 0; i < 3; i++) send_seq(8'hC0 + 4 * i, 4'hF, 1'b0, 1'b1);
    do_reset();
    push_exp(8'hE0, 17, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_seq(8'hE0 + 4 * i, 4'hF, 1'b0, 1'b0);
    send_seq(8'hF0, 4'h1, 1'b1, 1'b0);
    wait_drain("t6_drain");
    check("t6_pkt_count", 136'(pkt_count), 136'(1));
    check("t6_err_keep", 136'(err_keep), 136'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
